// File: rtl/subsoc_loader_pkg.sv
// Shared definitions for the OR32 program loader: state encoding, word geometry
// and state-decode helpers.
package subsoc_loader_pkg;

   localparam int         BYTES_PER_WORD = 4;
   localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_LEN   = 3'd2,
      ST_DATA  = 3'd3,
      ST_CKSUM = 3'd4,
      ST_WAIT  = 3'd5,
      ST_RUN   = 3'd6,
      ST_ERR   = 3'd7
   } ldr_state_e;

   // States in which the byte stream is consumed.
   function automatic logic accepts_bytes(input ldr_state_e st);
      logic r;
      case (st)
         ST_ADDR, ST_LEN, ST_DATA, ST_CKSUM: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_busy(input ldr_state_e st);
      logic r;
      case (st)
         ST_IDLE, ST_RUN, ST_ERR: r = 1'b0;
         default:                 r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/or32_ldr_word_asm.sv
// Byte-to-word assembler: collects BYTES_PER_WORD accepted bytes big-endian and
// presents the full word combinationally with the last byte.
module or32_ldr_word_asm
   import subsoc_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [31:0] word,
   output logic        word_vld
);

   logic [1:0]  byte_cnt_r;
   logic [23:0] shift_r;
   logic        accept_s;

   assign din_ready = en;
   assign accept_s  = din_valid & en;
   // The completing byte is used straight from din so the word is usable on its own edge.
   assign word      = {shift_r, din};
   assign word_vld  = accept_s & ~clr & (byte_cnt_r == LAST_BYTE_IDX);

   // Byte counter and shift register; clr discards any partial word.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         byte_cnt_r <= 2'd0;
         shift_r    <= 24'd0;
      end else if (accept_s) begin
         byte_cnt_r <= byte_cnt_r + 2'd1;
         shift_r    <= {shift_r[15:0], din};
      end else begin
         byte_cnt_r <= byte_cnt_r;
         shift_r    <= shift_r;
      end
   end

endmodule

// File: rtl/or32_prog_loader.sv
// OR32 program loader: parses address/length/data (and optional checksum when
// OR32_LOADER_CKSUM_EN is defined) from a byte stream, then releases the CPU.
module or32_prog_loader
   import subsoc_loader_pkg::*;
#(
   parameter int EN_DLY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_req_i,
   input  logic [7:0]  din_i,
   input  logic        din_valid_i,
   output logic        din_ready_o,
   output logic [31:0] or32_prog_addr_o,
   output logic [31:0] or32_prog_data_o,
   output logic        or32_prog_en_o,
   output logic        or32_en_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam logic [7:0] EN_DLY_C = 8'(EN_DLY);
`ifdef OR32_LOADER_CKSUM_EN
   localparam ldr_state_e ST_AFTER_DATA = ST_CKSUM;
`else
   localparam ldr_state_e ST_AFTER_DATA = ST_WAIT;
`endif

   ldr_state_e  state_r;
   logic [31:0] prog_addr_r;
   logic [31:0] prog_data_r;
   logic        prog_en_r;
   logic        cpu_en_r;
   logic [31:0] word_cnt_r;
   logic [7:0]  dly_r;
   logic [31:0] word_s;
   logic        word_vld_s;
`ifdef OR32_LOADER_CKSUM_EN
   logic [31:0] cksum_r;
`endif

   or32_ldr_word_asm u_word_asm (
      .clk       (clk),
      .reset     (reset),
      .clr       (load_req_i),
      .en        (accepts_bytes(state_r)),
      .din       (din_i),
      .din_valid (din_valid_i),
      .din_ready (din_ready_o),
      .word      (word_s),
      .word_vld  (word_vld_s)
   );

   assign or32_prog_addr_o = prog_addr_r;
   assign or32_prog_data_o = prog_data_r;
   assign or32_prog_en_o   = prog_en_r;
   assign or32_en_o        = cpu_en_r;
   assign busy_o           = is_busy(state_r);
`ifdef OR32_LOADER_CKSUM_EN
   assign err_o            = (state_r == ST_ERR);
`else
   assign err_o            = 1'b0;
`endif

   // Loader FSM with its datapath registers; load_req_i restarts from any state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         prog_addr_r <= 32'd0;
         prog_data_r <= 32'd0;
         prog_en_r   <= 1'b0;
         cpu_en_r    <= 1'b0;
         word_cnt_r  <= 32'd0;
         dly_r       <= 8'd0;
`ifdef OR32_LOADER_CKSUM_EN
         cksum_r     <= 32'd0;
`endif
      end else if (load_req_i) begin
         state_r    <= ST_ADDR;
         prog_en_r  <= 1'b0;
         cpu_en_r   <= 1'b0;
         word_cnt_r <= 32'd0;
         dly_r      <= 8'd0;
`ifdef OR32_LOADER_CKSUM_EN
         cksum_r    <= 32'd0;
`endif
      end else begin
         prog_en_r <= 1'b0;
         // The strobe cycle shows the current address; advance once it is done.
         if (prog_en_r) begin
            prog_addr_r <= prog_addr_r + 32'd4;
         end else begin
            prog_addr_r <= prog_addr_r;
         end
         case (state_r)
            ST_IDLE: begin
               state_r <= ST_IDLE;
            end
            ST_ADDR: begin
               if (word_vld_s) begin
                  prog_addr_r <= {word_s[31:2], 2'b00};
                  state_r     <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (word_vld_s) begin
                  word_cnt_r <= word_s;
                  dly_r      <= 8'd0;
                  state_r    <= (word_s == 32'd0) ? ST_AFTER_DATA : ST_DATA;
               end
            end
            ST_DATA: begin
               if (word_vld_s) begin
                  prog_data_r <= word_s;
                  prog_en_r   <= 1'b1;
                  word_cnt_r  <= word_cnt_r - 32'd1;
`ifdef OR32_LOADER_CKSUM_EN
                  cksum_r     <= cksum_r + word_s;
`endif
                  if (word_cnt_r == 32'd1) begin
                     dly_r   <= 8'd0;
                     state_r <= ST_AFTER_DATA;
                  end
               end
            end
`ifdef OR32_LOADER_CKSUM_EN
            ST_CKSUM: begin
               if (word_vld_s) begin
                  dly_r   <= 8'd0;
                  state_r <= (word_s == cksum_r) ? ST_WAIT : ST_ERR;
               end
            end
            ST_ERR: begin
               cpu_en_r <= 1'b0;
            end
`endif
            // The strobe cycle is not idle, so count one extra to give EN_DLY idle cycles.
            ST_WAIT: begin
               if (dly_r == EN_DLY_C) begin
                  cpu_en_r <= 1'b1;
                  state_r  <= ST_RUN;
               end else begin
                  dly_r <= dly_r + 8'd1;
               end
            end
            ST_RUN: begin
               cpu_en_r <= 1'b1;
            end
            default: begin
               state_r  <= ST_IDLE;
               cpu_en_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_or32_prog_loader.sv
// Directed self-checking bench for or32_prog_loader (checksum tests follow OR32_LOADER_CKSUM_EN).
module tb_or32_prog_loader;

   localparam int EN_DLY = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_req_i;
   logic [7:0]  din_i;
   logic        din_valid_i;
   logic        din_ready_o;
   logic [31:0] or32_prog_addr_o;
   logic [31:0] or32_prog_data_o;
   logic        or32_prog_en_o;
   logic        or32_en_o;
   logic        busy_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = 0;
   int n_strobe = 0;
   int en_cnt = 0;
   logic [31:0] st_addr [0:15];
   logic [31:0] st_data [0:15];
   int          st_cyc  [0:15];

   or32_prog_loader #(.EN_DLY(EN_DLY)) dut (
      .clk              (clk),
      .reset            (reset),
      .load_req_i       (load_req_i),
      .din_i            (din_i),
      .din_valid_i      (din_valid_i),
      .din_ready_o      (din_ready_o),
      .or32_prog_addr_o (or32_prog_addr_o),
      .or32_prog_data_o (or32_prog_data_o),
      .or32_prog_en_o   (or32_prog_en_o),
      .or32_en_o        (or32_en_o),
      .busy_o           (busy_o),
      .err_o            (err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (or32_prog_en_o) begin
         if (n_strobe < 16) begin
            st_addr[n_strobe] = or32_prog_addr_o;
            st_data[n_strobe] = or32_prog_data_o;
            st_cyc[n_strobe]  = cyc;
         end
         n_strobe++;
      end
      if (or32_en_o) en_cnt++;
   end

   task automatic send_byte(input logic [7:0] b);
      bit acc;
      acc = 1'b0;
      din_i = b;
      din_valid_i = 1'b1;
      for (int i = 0; i < 50; i++) begin
         acc = din_ready_o;
         @(negedge clk);
         if (acc) break;
      end
      din_valid_i = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL byte_accept: din_ready_o stayed 0, byte %h not taken", b);
      end else begin
         last_acc = cyc;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[31-8*i -: 8]);
         if (gap) @(negedge clk);
      end
   endtask

   task automatic pulse_load();
      load_req_i = 1'b1;
      @(negedge clk);
      load_req_i = 1'b0;
   endtask

   task automatic wait_en(output int rise, output bit ok);
      ok = 1'b0;
      rise = 0;
      for (int i = 0; i < 600; i++) begin
         if (or32_en_o) begin
            ok = 1'b1;
            rise = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; load_req_i = 1'b0; din_i = 8'h00; din_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      load_req_i = 1'b1;
      @(negedge clk);
      checks++;
      if ({din_ready_o, or32_prog_en_o, or32_en_o, busy_o, err_o} !== 5'b0 ||
          or32_prog_addr_o !== 32'h0 || or32_prog_data_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b pen=%b en=%b busy=%b err=%b addr=%h data=%h, need all 0",
                  din_ready_o, or32_prog_en_o, or32_en_o, busy_o, err_o, or32_prog_addr_o, or32_prog_data_o);
      end
      load_req_i = 1'b0; reset = 1'b0;
      din_i = 8'h5A; din_valid_i = 1'b1;
      repeat (2) @(negedge clk);
      din_valid_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || din_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_beats_load: busy=%b rdy=%b, need 0 0 (IDLE)", busy_o, din_ready_o);
      end
   endtask

   task automatic test_basic();
      int base; int rise; int dacc; bit ok;
      base = n_strobe;
      pulse_load();
      checks++;
      if (busy_o !== 1'b1 || din_ready_o !== 1'b1 || or32_en_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_addr_state: busy=%b rdy=%b en=%b, need 1 1 0", busy_o, din_ready_o, or32_en_o);
      end
      send_word(32'h0000_0100, 1'b0);
      send_word(32'h0000_0002, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      send_word(32'h0123_4567, 1'b0);
      dacc = last_acc;
`ifdef OR32_LOADER_CKSUM_EN
      send_word(32'hDFD1_0456, 1'b0);
`endif
      wait_en(rise, ok);
      checks++;
      if (n_strobe - base != 2) begin
         errors++;
         $display("FAIL basic_strobe_count: got %0d, need 2", n_strobe - base);
      end
      checks++;
      if (st_addr[base] !== 32'h100 || st_data[base] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL basic_strobe0: addr=%h data=%h, need 00000100 deadbeef", st_addr[base], st_data[base]);
      end
      checks++;
      if (st_addr[base+1] !== 32'h104 || st_data[base+1] !== 32'h01234567) begin
         errors++;
         $display("FAIL basic_strobe1: addr=%h data=%h, need 00000104 01234567", st_addr[base+1], st_data[base+1]);
      end
      checks++;
      if (st_cyc[base+1] != dacc) begin
         errors++;
         $display("FAIL basic_strobe_latency: strobe cycle %0d, need %0d", st_cyc[base+1], dacc);
      end
      checks++;
      if (!ok || rise != last_acc + EN_DLY + 1) begin
         errors++;
         $display("FAIL basic_en_rise: ok=%b cycle %0d, need %0d", ok, rise, last_acc + EN_DLY + 1);
      end
      checks++;
      if (busy_o !== 1'b0 || din_ready_o !== 1'b0 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_run_flags: busy=%b rdy=%b err=%b, need 0 0 0", busy_o, din_ready_o, err_o);
      end
   endtask

   task automatic test_zero_len();
      int base; int rise; bit ok;
      base = n_strobe;
      pulse_load();
      checks++;
      if (or32_en_o !== 1'b0) begin
         errors++;
         $display("FAIL zero_en_drop: en=%b, need 0 after load_req", or32_en_o);
      end
      send_word(32'h0000_0000, 1'b0);
      send_word(32'h0000_0000, 1'b0);
`ifdef OR32_LOADER_CKSUM_EN
      send_word(32'h0000_0000, 1'b0);
`endif
      wait_en(rise, ok);
      checks++;
      if (n_strobe != base) begin
         errors++;
         $display("FAIL zero_no_strobe: got %0d strobes, need 0", n_strobe - base);
      end
      checks++;
      if (!ok || rise != last_acc + EN_DLY + 1) begin
         errors++;
         $display("FAIL zero_en_rise: ok=%b cycle %0d, need %0d", ok, rise, last_acc + EN_DLY + 1);
      end
   endtask

   task automatic test_restart();
      int base; int en_base; int rise; bit ok;
      base = n_strobe;
      pulse_load();
      en_base = en_cnt;
      send_word(32'h0000_0200, 1'b0);
      send_word(32'h0000_0003, 1'b0);
      send_word(32'h1111_1111, 1'b0);
      send_byte(8'h22);
      send_byte(8'h22);
      pulse_load();
      checks++;
      if (n_strobe - base != 1 || busy_o !== 1'b1 || din_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL restart_mid_data: strobes=%0d busy=%b rdy=%b, need 1 1 1", n_strobe - base, busy_o, din_ready_o);
      end
      send_word(32'h0000_0400, 1'b0);
      send_word(32'h0000_0002, 1'b0);
      send_word(32'h3333_3333, 1'b0);
      send_byte(8'h44); send_byte(8'h44); send_byte(8'h44);
      din_i = 8'h44; din_valid_i = 1'b1; load_req_i = 1'b1;
      @(negedge clk);
      din_valid_i = 1'b0; load_req_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (n_strobe - base != 2 || st_addr[base+1] !== 32'h400) begin
         errors++;
         $display("FAIL restart_collision: strobes=%0d addr=%h, need 2 00000400", n_strobe - base, st_addr[base+1]);
      end
      send_word(32'h0000_0302, 1'b0);
      send_word(32'h0000_0001, 1'b0);
      send_word(32'hCAFE_F00D, 1'b0);
      @(negedge clk);
      checks++;
      if (n_strobe - base != 3 || st_addr[base+2] !== 32'h300 || st_data[base+2] !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL restart_new_session: strobes=%0d addr=%h data=%h, need 3 00000300 cafef00d",
                  n_strobe - base, st_addr[base+2], st_data[base+2]);
      end
      checks++;
      if (en_cnt != en_base) begin
         errors++;
         $display("FAIL restart_en_low: en high for %0d cycles, need 0", en_cnt - en_base);
      end
`ifdef OR32_LOADER_CKSUM_EN
      send_word(32'hCAFE_F00D, 1'b0);
`endif
      wait_en(rise, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL restart_en_rise: en never rose, need 1");
      end
   endtask

   task automatic test_wrap_stall();
      int base; int rise; bit ok;
      base = n_strobe;
      pulse_load();
      send_word(32'hFFFF_FFFC, 1'b1);
      send_word(32'h0000_0002, 1'b1);
      send_word(32'h1357_9BDF, 1'b1);
      @(negedge clk);
      checks++;
      if (or32_prog_data_o !== 32'h13579BDF || or32_prog_addr_o !== 32'h0 || or32_prog_en_o !== 1'b0) begin
         errors++;
         $display("FAIL wrap_hold: addr=%h data=%h pen=%b, need 00000000 13579bdf 0",
                  or32_prog_addr_o, or32_prog_data_o, or32_prog_en_o);
      end
      send_word(32'h2468_ACE0, 1'b1);
`ifdef OR32_LOADER_CKSUM_EN
      send_word(32'h37C0_48BF, 1'b1);
`endif
      wait_en(rise, ok);
      checks++;
      if (n_strobe - base != 2 || st_addr[base] !== 32'hFFFFFFFC || st_data[base] !== 32'h13579BDF) begin
         errors++;
         $display("FAIL wrap_strobe0: n=%0d addr=%h data=%h, need 2 fffffffc 13579bdf",
                  n_strobe - base, st_addr[base], st_data[base]);
      end
      checks++;
      if (st_addr[base+1] !== 32'h0 || st_data[base+1] !== 32'h2468ACE0 || !ok) begin
         errors++;
         $display("FAIL wrap_strobe1: addr=%h data=%h en_ok=%b, need 00000000 2468ace0 1",
                  st_addr[base+1], st_data[base+1], ok);
      end
   endtask

`ifdef OR32_LOADER_CKSUM_EN
   task automatic test_bad_cksum();
      pulse_load();
      send_word(32'h0000_0100, 1'b0);
      send_word(32'h0000_0002, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      send_word(32'h0123_4567, 1'b0);
      send_word(32'h0000_0000, 1'b0);
      repeat (EN_DLY + 4) @(negedge clk);
      checks++;
      if (err_o !== 1'b1 || or32_en_o !== 1'b0 || din_ready_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL bad_cksum_err: err=%b en=%b rdy=%b busy=%b, need 1 0 0 0",
                  err_o, or32_en_o, din_ready_o, busy_o);
      end
      pulse_load();
      checks++;
      if (err_o !== 1'b0 || din_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL bad_cksum_clear: err=%b rdy=%b, need 0 1", err_o, din_ready_o);
      end
   endtask
`endif

   task automatic test_reset_mid_data();
      pulse_load();
      send_word(32'h0000_0100, 1'b0);
      send_word(32'h0000_0002, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      send_byte(8'h01);
      send_byte(8'h23);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({din_ready_o, or32_prog_en_o, or32_en_o, busy_o, err_o} !== 5'b0 ||
          or32_prog_addr_o !== 32'h0 || or32_prog_data_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_data: rdy=%b pen=%b en=%b busy=%b err=%b addr=%h data=%h, need all 0",
                  din_ready_o, or32_prog_en_o, or32_en_o, busy_o, err_o, or32_prog_addr_o, or32_prog_data_o);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_zero_len();
      test_restart();
      test_wrap_stall();
`ifdef OR32_LOADER_CKSUM_EN
      test_bad_cksum();
`endif
      test_reset_mid_data();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/or32_prog_loader.md
OR32_PROG_LOADER -- requirements
Module: or32_prog_loader

Interface
REQ-001 Parameter EN_DLY, default 4: idle cycles from the last prog write to or32_en_o rising; range 1..255.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 load_req_i  in  1  one-cycle pulse that starts or restarts a load session.
REQ-005 din_i  in  8  byte stream, most significant byte first.
REQ-006 din_valid_i  in  1  din_i holds a byte.
REQ-007 din_ready_o  out  1  loader accepts din_i; a byte transfers when din_valid_i and din_ready_o are both high.
REQ-008 or32_prog_addr_o  out  32  byte address of the word being programmed.
REQ-009 or32_prog_data_o  out  32  word being programmed.
REQ-010 or32_prog_en_o  out  1  one-cycle write strobe.
REQ-011 or32_en_o  out  1  (1) CPU runs, (0) CPU held in reset.
REQ-012 busy_o  out  1  high in every state except IDLE, RUN and ERR.
REQ-013 err_o  out  1  high in ERR.

Function
REQ-014 States: IDLE, ADDR, LEN, DATA, CKSUM, WAIT, RUN, ERR.
REQ-015 din_ready_o is 1 in ADDR, LEN, DATA and CKSUM, and 0 in every other state.
REQ-016 A 2-bit byte counter assembles 4 accepted bytes into one 32-bit word, big-endian: the first byte lands in bits [31:24].
REQ-017 load_req_i in any state forces or32_en_o=0 on the next cycle, clears the byte counter and err_o, and enters ADDR; this holds mid-word and mid-DATA, and the partial word is discarded.
REQ-018 ADDR: the 4th byte latches the start address into or32_prog_addr_o and moves to LEN; address bits [1:0] are forced to 0.
REQ-019 LEN: the 4th byte latches the 32-bit word count; a count of 0 goes directly to CKSUM (or to WAIT when checksum is compiled out); otherwise the state moves to DATA.
REQ-020 DATA: on the cycle after the 4th byte of each word, or32_prog_en_o is 1 for exactly one cycle, with or32_prog_data_o = the assembled word and or32_prog_addr_o = the current address.
REQ-021 After each strobe, the address increments by 4 (modulo 2^32, wraps silently) and the remaining count decrements by 1.
REQ-022 When the count reaches 0 after a strobe, the state moves to CKSUM (or to WAIT when checksum is compiled out).
REQ-023 or32_prog_addr_o and or32_prog_data_o hold their values between strobes.
REQ-024 WAIT: an 8-bit counter counts EN_DLY cycles, then the state moves to RUN; RUN drives or32_en_o=1.
REQ-025 din_valid_i low stalls assembly indefinitely with no timeout; bytes presented in IDLE, RUN or ERR are not accepted.
REQ-026 A load_req_i pulse in the same cycle as the 4th byte of a word wins: no strobe is issued and the state goes to ADDR.

Reset
REQ-027 While reset is high: state=IDLE, or32_en_o=0, or32_prog_en_o=0, din_ready_o=0, busy_o=0, err_o=0, or32_prog_addr_o=0, or32_prog_data_o=0, and all counters cleared.
REQ-028 Reset dominates load_req_i in the same cycle.

Configuration
REQ-029 With macro OR32_LOADER_CKSUM_EN defined: a 32-bit accumulator sums all data words (modulo 2^32) and clears on entry to ADDR.
REQ-030 With OR32_LOADER_CKSUM_EN defined: CKSUM accepts 4 bytes; if they match the accumulator, the state moves to WAIT; otherwise it moves to ERR, with or32_en_o=0 and err_o=1 until the next load_req_i or reset.
REQ-031 Without OR32_LOADER_CKSUM_EN: the CKSUM state, the accumulator and ERR are absent, and err_o is tied to 0.

Structure
REQ-032 A shared package subsoc_loader_pkg holds the state encoding and the byte-count constant BYTES_PER_WORD=4.
REQ-033 Exactly one sub-module, or32_ldr_word_asm, handles byte-to-word assembly: valid/ready in, 32-bit word plus one-cycle word_vld out, and a synchronous clear.
REQ-034 or32_prog_addr_o, or32_prog_data_o and or32_prog_en_o connect directly to the OR32 program interface; the RAM index is taken from address bits [MEMORY_ADR_WIDTH+1:2] downstream.

Verification
REQ-035 Basic load: load_req, then stream 00 00 01 00 | 00 00 00 02 | DE AD BE EF | 01 23 45 67 (plus checksum DF D1 04 56 when enabled) -> strobes at addr 0x100/data 0xDEADBEEF and 0x104/0x01234567; or32_en_o rises EN_DLY+1 cycles after the 2nd strobe.
REQ-036 Zero length: address 0x0 with count 0 -> no strobe; or32_en_o rises after WAIT (checksum 00000000 when enabled).
REQ-037 Restart: load_req after 2 bytes of the second DATA word -> no further strobe; the new session restarts at its own ADDR; or32_en_o stays 0 throughout.
REQ-038 Wrap and stall: start 0xFFFFFFFC, count 2, din_valid_i toggling every cycle -> strobes at 0xFFFFFFFC then 0x00000000, with data intact.
REQ-039 Bad checksum (macro on): basic load with checksum 00000000 -> err_o=1, or32_en_o=0 and din_ready_o=0 until the next load_req.
REQ-040 Reset mid-DATA: all outputs return to their REQ-027 values on the next cycle.
